// File: rtl/mcam_ctrl_pkg.sv
// Shared definitions for the memory-access protection controller:
// register map, CTRL bit positions and the reset-sequencer state encoding.
package mcam_ctrl_pkg;

   localparam logic [2:0] OFF_CTRL      = 3'd0;
   localparam logic [2:0] OFF_LOW_SAFE  = 3'd1;
   localparam logic [2:0] OFF_HIGH_SAFE = 3'd2;
   localparam logic [2:0] OFF_LOW_CODE  = 3'd3;
   localparam logic [2:0] OFF_HIGH_CODE = 3'd4;
   localparam logic [2:0] OFF_STATUS    = 3'd5;
   localparam logic [2:0] OFF_VADDR     = 3'd6;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_LOCK    = 1;
   localparam int CTRL_DBG_DIS = 2;
   localparam int CTRL_IE      = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/mcam_rst_seq.sv
// Violation reset sequencer: a trigger in IDLE produces an RST_CYCLES-long
// reset pulse followed by a HOLD_CYCLES hold-off during which triggers are ignored.
module mcam_rst_seq
   import mcam_ctrl_pkg::*;
#(
   parameter logic [7:0] RST_CYCLES  = 8'd16,
   parameter logic [7:0] HOLD_CYCLES = 8'd32
) (
   input  logic clk,
   input  logic rst,
   input  logic i_trigger,
   output logic o_viol_rst
);

   seq_state_t r_state;
   seq_state_t w_state_next;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // The counter holds "cycles remaining minus one" in the current state.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (i_trigger) begin
               w_state_next = ST_ASSERT;
               w_cnt_next   = RST_CYCLES - 8'd1;
            end
         end
         ST_ASSERT: begin
            if (r_cnt == 8'd0) begin
               if (HOLD_CYCLES == 8'd0) begin
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_HOLD;
                  w_cnt_next   = HOLD_CYCLES - 8'd1;
               end
            end else begin
               w_cnt_next = r_cnt - 8'd1;
            end
         end
         ST_HOLD: begin
            if (r_cnt == 8'd0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 8'd0;
         end
      endcase
   end

   assign o_viol_rst = (r_state == ST_ASSERT);

endmodule

// File: rtl/mcam_ctrl.sv
// Peripheral-bus register file, violation status capture and interrupt for the
// memory-access protection checker; the reset pulse timing lives in mcam_rst_seq.
module mcam_ctrl
   import mcam_ctrl_pkg::*;
#(
   parameter logic [13:0] BASE_ADDR   = 14'h0090,
   parameter logic [7:0]  RST_CYCLES  = 8'd16,
   parameter logic [7:0]  HOLD_CYCLES = 8'd32
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   input  logic        viol,
   input  logic [15:0] viol_addr,
   output logic [15:0] low_safe,
   output logic [15:0] high_safe,
   output logic [15:0] low_code,
   output logic [15:0] high_code,
   output logic        prot_en,
   output logic        viol_rst,
   output logic        irq
);

   logic [3:0]  r_ctrl;
   logic [15:0] r_low_safe;
   logic [15:0] r_high_safe;
   logic [15:0] r_low_code;
   logic [15:0] r_high_code;
   logic        r_vflag;
   logic [7:0]  r_vcnt;
   logic [15:0] r_vaddr;
   logic        r_irq;

   logic [13:0] w_off_full;
   logic [2:0]  w_off;
   logic        w_hit;
   logic        w_wr_sel;
   logic        w_rd_sel;
   logic        w_locked;
   logic        w_prot_en;
   logic        w_count;
   logic        w_status_clr;
   logic [15:0] w_rdata;

   // Eight-word window; offsets 7 and beyond decode as unmapped.
   assign w_off_full   = per_addr - BASE_ADDR;
   assign w_hit        = (w_off_full < 14'd8);
   assign w_off        = w_off_full[2:0];
   assign w_wr_sel     = per_en & (|per_we) & w_hit;
   assign w_rd_sel     = per_en & ~(|per_we) & w_hit;
   assign w_locked     = r_ctrl[CTRL_LOCK];
   assign w_prot_en    = r_ctrl[CTRL_EN] & ~r_ctrl[CTRL_DBG_DIS];
   assign w_count      = viol & w_prot_en;
   assign w_status_clr = w_wr_sel & (w_off == OFF_STATUS) & per_din[0];

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_ctrl      <= 4'd0;
         r_low_safe  <= 16'd0;
         r_high_safe <= 16'd0;
         r_low_code  <= 16'd0;
         r_high_code <= 16'd0;
      end else if (w_wr_sel) begin
         case (w_off)
            OFF_CTRL: begin
               r_ctrl[CTRL_IE] <= per_din[CTRL_IE];
               if (per_din[CTRL_LOCK]) r_ctrl[CTRL_LOCK] <= 1'b1;
               if (!w_locked) begin
                  r_ctrl[CTRL_EN]      <= per_din[CTRL_EN];
                  r_ctrl[CTRL_DBG_DIS] <= per_din[CTRL_DBG_DIS];
               end
            end
            OFF_LOW_SAFE:  if (!w_locked) r_low_safe  <= per_din;
            OFF_HIGH_SAFE: if (!w_locked) r_high_safe <= per_din;
            OFF_LOW_CODE:  if (!w_locked) r_low_code  <= per_din;
            OFF_HIGH_CODE: if (!w_locked) r_high_code <= per_din;
            default: ;
         endcase
      end
   end

   // A violation in the same cycle as a STATUS clear wins: the clear is
   // folded in by restarting the count at 1 and re-latching the address.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_vflag <= 1'b0;
         r_vcnt  <= 8'd0;
         r_vaddr <= 16'd0;
         r_irq   <= 1'b0;
      end else begin
         if (w_count) begin
            r_vflag <= 1'b1;
            if (w_status_clr)
               r_vcnt <= 8'd1;
            else if (r_vcnt != 8'hFF)
               r_vcnt <= r_vcnt + 8'd1;
            if (!r_vflag || w_status_clr)
               r_vaddr <= viol_addr;
         end else if (w_status_clr) begin
            r_vflag <= 1'b0;
            r_vcnt  <= 8'd0;
         end
         r_irq <= r_vflag & r_ctrl[CTRL_IE];
      end
   end

   always_comb begin
      w_rdata = 16'd0;
      if (w_rd_sel) begin
         case (w_off)
            OFF_CTRL:      w_rdata = {12'd0, r_ctrl};
            OFF_LOW_SAFE:  w_rdata = r_low_safe;
            OFF_HIGH_SAFE: w_rdata = r_high_safe;
            OFF_LOW_CODE:  w_rdata = r_low_code;
            OFF_HIGH_CODE: w_rdata = r_high_code;
            OFF_STATUS:    w_rdata = {r_vcnt, 7'd0, r_vflag};
            OFF_VADDR:     w_rdata = r_vaddr;
            default:       w_rdata = 16'd0;
         endcase
      end
   end

   mcam_rst_seq #(
      .RST_CYCLES  (RST_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_rst_seq (
      .clk        (mclk),
      .rst        (puc_rst),
      .i_trigger  (w_count),
      .o_viol_rst (viol_rst)
   );

   assign per_dout  = w_rdata;
   assign low_safe  = r_low_safe;
   assign high_safe = r_high_safe;
   assign low_code  = r_low_code;
   assign high_code = r_high_code;
   assign prot_en   = w_prot_en;
   assign irq       = r_irq;

endmodule

// File: tb/tb_mcam_ctrl.sv
// Directed bench for mcam_ctrl: expected values are queued as each step is
// driven and popped when the corresponding DUT output is observed.
module tb_mcam_ctrl;

   localparam logic [13:0] BASE = 14'h0090;

   logic        mclk = 1'b0;
   logic        puc_rst = 1'b1;
   logic [13:0] per_addr = 14'd0;
   logic [15:0] per_din = 16'd0;
   logic        per_en = 1'b0;
   logic [1:0]  per_we = 2'b00;
   logic [15:0] per_dout;
   logic        viol = 1'b0;
   logic [15:0] viol_addr = 16'd0;
   logic [15:0] low_safe, high_safe, low_code, high_code;
   logic        prot_en, viol_rst, irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;
   exp_t sb_q[$];

   mcam_ctrl #(
      .BASE_ADDR   (BASE),
      .RST_CYCLES  (8'd16),
      .HOLD_CYCLES (8'd32)
   ) dut (
      .mclk      (mclk),
      .puc_rst   (puc_rst),
      .per_addr  (per_addr),
      .per_din   (per_din),
      .per_en    (per_en),
      .per_we    (per_we),
      .per_dout  (per_dout),
      .viol      (viol),
      .viol_addr (viol_addr),
      .low_safe  (low_safe),
      .high_safe (high_safe),
      .low_code  (low_code),
      .high_code (high_code),
      .prot_en   (prot_en),
      .viol_rst  (viol_rst),
      .irq       (irq)
   );

   always #5 mclk = ~mclk;

   task automatic push_exp(input string tag, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input logic [15:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
         $display("check %-14s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   task automatic check_sig(input string tag, input logic [15:0] obs, input logic [15:0] val);
      push_exp(tag, val);
      pop_check(obs);
   endtask

   // All tasks start and end just after a falling edge.
   task automatic bus_write(input logic [2:0] off, input logic [15:0] data);
      per_addr = BASE + {11'd0, off};
      per_din  = data;
      per_we   = 2'b11;
      per_en   = 1'b1;
      @(negedge mclk);
      per_en   = 1'b0;
      per_we   = 2'b00;
   endtask

   task automatic bus_read(input logic [13:0] addr, output logic [15:0] data);
      per_addr = addr;
      per_we   = 2'b00;
      per_en   = 1'b1;
      #1;
      data     = per_dout;
      per_en   = 1'b0;
   endtask

   task automatic reg_check(input string tag, input logic [2:0] off, input logic [15:0] val);
      logic [15:0] d;
      push_exp(tag, val);
      bus_read(BASE + {11'd0, off}, d);
      pop_check(d);
   endtask

   task automatic pulse_viol(input logic [15:0] addr);
      viol      = 1'b1;
      viol_addr = addr;
      @(negedge mclk);
      viol      = 1'b0;
   endtask

   task automatic measure_pulse(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (viol_rst) n++;
         else if (n > 0) break;
         @(negedge mclk);
      end
   endtask

   initial begin
      logic [15:0] d;
      int          n;
      int          seen;

      // Reset state
      repeat (2) @(negedge mclk);
      check_sig("rst_viol_rst", 16'(viol_rst), 16'h0000);
      check_sig("rst_irq", 16'(irq), 16'h0000);
      puc_rst = 1'b0;
      @(negedge mclk);
      check_sig("rst_prot_en", 16'(prot_en), 16'h0000);
      check_sig("rst_low_safe", low_safe, 16'h0000);
      check_sig("rst_high_code", high_code, 16'h0000);
      reg_check("rst_ctrl", 3'd0, 16'h0000);
      reg_check("rst_status", 3'd5, 16'h0000);
      reg_check("rst_vaddr", 3'd6, 16'h0000);

      // Configuration
      bus_write(3'd1, 16'h0200);
      bus_write(3'd2, 16'h02FF);
      bus_write(3'd0, 16'h0001);
      check_sig("cfg_low_out", low_safe, 16'h0200);
      check_sig("cfg_high_out", high_safe, 16'h02FF);
      check_sig("cfg_prot_en", 16'(prot_en), 16'h0001);
      reg_check("cfg_low_rd", 3'd1, 16'h0200);
      reg_check("cfg_high_rd", 3'd2, 16'h02FF);
      per_addr = BASE;
      per_en   = 1'b0;
      #1;
      check_sig("unselected_rd", per_dout, 16'h0000);
      bus_write(3'd7, 16'hFFFF);
      reg_check("off7_rd", 3'd7, 16'h0000);
      bus_read(BASE + 14'd8, d);
      check_sig("outside_rd", d, 16'h0000);

      // Lock
      bus_write(3'd0, 16'h0003);
      bus_write(3'd1, 16'h1234);
      bus_write(3'd0, 16'h0000);
      check_sig("lock_low_out", low_safe, 16'h0200);
      reg_check("lock_ctrl", 3'd0, 16'h0003);
      check_sig("lock_prot_en", 16'(prot_en), 16'h0001);
      bus_write(3'd0, 16'h0008);
      reg_check("lock_ie", 3'd0, 16'h000B);

      // Violation response
      pulse_viol(16'h0210);
      check_sig("irq_lag", 16'(irq), 16'h0000);
      reg_check("v1_status", 3'd5, 16'h0101);
      measure_pulse(n);
      check_sig("v1_pulse_len", 16'(n), 16'd16);
      reg_check("v1_vaddr", 3'd6, 16'h0210);
      check_sig("v1_irq", 16'(irq), 16'h0001);

      // Hold-off: pulse during HOLD must not retrigger
      pulse_viol(16'h0220);
      seen = 0;
      repeat (20) begin
         if (viol_rst) seen++;
         @(negedge mclk);
      end
      check_sig("hold_no_rst", 16'(seen), 16'd0);
      reg_check("hold_status", 3'd5, 16'h0201);
      reg_check("hold_vaddr", 3'd6, 16'h0210);
      repeat (20) @(negedge mclk);
      pulse_viol(16'h0240);
      measure_pulse(n);
      check_sig("v3_pulse_len", 16'(n), 16'd16);

      // Last HOLD cycle ignores viol; the next cycle retriggers
      repeat (31) @(negedge mclk);
      pulse_viol(16'h0250);
      check_sig("hold_last_edge", 16'(viol_rst), 16'h0000);
      pulse_viol(16'h0260);
      check_sig("idle_first_edge", 16'(viol_rst), 16'h0001);
      measure_pulse(n);
      check_sig("v5_pulse_len", 16'(n), 16'd16);
      reg_check("v5_status", 3'd5, 16'h0501);

      // Read-only fields
      bus_write(3'd6, 16'hFFFF);
      reg_check("vaddr_ro", 3'd6, 16'h0210);
      bus_write(3'd5, 16'hFF00);
      reg_check("vcnt_ro", 3'd5, 16'h0501);

      // Violation and STATUS clear in the same cycle
      per_addr  = BASE + 14'd5;
      per_din   = 16'h0001;
      per_we    = 2'b11;
      per_en    = 1'b1;
      viol      = 1'b1;
      viol_addr = 16'h0230;
      @(negedge mclk);
      per_en = 1'b0;
      per_we = 2'b00;
      viol   = 1'b0;
      reg_check("vc_status", 3'd5, 16'h0101);
      reg_check("vc_vaddr", 3'd6, 16'h0230);

      // Plain clear: irq falls one cycle later
      bus_write(3'd5, 16'h0001);
      check_sig("clr_irq_lag", 16'(irq), 16'h0001);
      reg_check("clr_status", 3'd5, 16'h0000);
      @(negedge mclk);
      check_sig("clr_irq", 16'(irq), 16'h0000);

      // Gating with DBG_DIS after a fresh reset
      repeat (40) @(negedge mclk);
      puc_rst = 1'b1;
      @(negedge mclk);
      puc_rst = 1'b0;
      reg_check("rerst_ctrl", 3'd0, 16'h0000);
      bus_write(3'd1, 16'h0200);
      bus_write(3'd0, 16'h0005);
      check_sig("dbg_prot_en", 16'(prot_en), 16'h0000);
      viol      = 1'b1;
      viol_addr = 16'h0300;
      seen      = 0;
      repeat (300) begin
         @(negedge mclk);
         if (viol_rst) seen++;
      end
      viol = 1'b0;
      check_sig("dbg_no_rst", 16'(seen), 16'd0);
      reg_check("dbg_status", 3'd5, 16'h0000);

      // Saturation
      bus_write(3'd0, 16'h0009);
      viol = 1'b1;
      repeat (300) @(negedge mclk);
      viol = 1'b0;
      reg_check("sat_status", 3'd5, 16'hFF01);
      reg_check("sat_vaddr", 3'd6, 16'h0300);
      repeat (60) @(negedge mclk);

      // Asynchronous reset mid-ASSERT
      pulse_viol(16'h0310);
      repeat (4) @(negedge mclk);
      check_sig("pre_rst_rst", 16'(viol_rst), 16'h0001);
      check_sig("pre_rst_irq", 16'(irq), 16'h0001);
      #2;
      puc_rst = 1'b1;
      #1;
      check_sig("arst_viol_rst", 16'(viol_rst), 16'h0000);
      check_sig("arst_irq", 16'(irq), 16'h0000);
      check_sig("arst_prot_en", 16'(prot_en), 16'h0000);
      check_sig("arst_low_safe", low_safe, 16'h0000);
      reg_check("arst_status", 3'd5, 16'h0000);
      reg_check("arst_vaddr", 3'd6, 16'h0000);
      @(negedge mclk);
      puc_rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge mclk);
         if (viol_rst) seen++;
      end
      check_sig("post_rst_idle", 16'(seen), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
